window_scan_ctrl: RTL and testbench

//  Sequences the pixel-address datapath for the cascade classifier: raster-scans a WIN_WIDTH x WIN_HEIGHT

---
 rtl/window_scan_pkg.sv | 41 ++++
 rtl/wrap_cnt.sv | 50 +++++
 rtl/window_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_window_scan_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_scan_pkg.sv
// ============================================================================
// Module      : window_scan_pkg
// Description : Shared types, width helpers and default geometry for the
//               window scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package window_scan_pkg;

    // Width of a coordinate bus able to address 0..n-1; never narrower than 1 bit
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of window origins along one axis
    function automatic int calc_positions(input int img, input int win, input int step);
        return (img - win) / step + 1;
    endfunction

    localparam int DEF_IMG_WIDTH  = 41;
    localparam int DEF_IMG_HEIGHT = 50;
    localparam int DEF_WIN_WIDTH  = 24;
    localparam int DEF_WIN_HEIGHT = 24;
    localparam int DEF_STEP       = 1;

    localparam int W_X = calc_width(DEF_IMG_WIDTH);
    localparam int W_Y = calc_width(DEF_IMG_HEIGHT);
    localparam int NX  = calc_positions(DEF_IMG_WIDTH, DEF_WIN_WIDTH, DEF_STEP);
    localparam int NY  = calc_positions(DEF_IMG_HEIGHT, DEF_WIN_HEIGHT, DEF_STEP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/wrap_cnt.sv
// ============================================================================
// Module      : wrap_cnt
// Description : Up-counter stepping by INC that returns to 0 instead of
//               passing MAX; exposes its next value for output registering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_cnt #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15,
    parameter int INC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] c_inc = WIDTH'(INC);

    logic [WIDTH-1:0] r_cnt;

    // Terminal count: another step would pass MAX (evaluated in int, so no overflow)
    assign wrap = (int'(r_cnt) + INC) > MAX;
    assign cnt  = r_cnt;

    always_comb begin
        nxt = r_cnt;
        if (clr) begin
            nxt = '0;
        end else if (en) begin
            nxt = wrap ? '0 : r_cnt + c_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_scan_ctrl.sv
// ============================================================================
// Module      : window_scan_ctrl
// Description : Raster-scans a detection window over the image and streams
//               absolute pixel coordinates over valid/ready, waiting for the
//               classifier verdict between windows.
//               Optional macro SCAN_SKIP_EN adds the win_skip abort input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_scan_ctrl
    import window_scan_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int WIN_WIDTH  = DEF_WIN_WIDTH,
    parameter int WIN_HEIGHT = DEF_WIN_HEIGHT,
    parameter int STEP       = DEF_STEP
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                coord_valid,
    input  logic                                coord_ready,
    output logic [calc_width(IMG_WIDTH)-1:0]    x,
    output logic [calc_width(IMG_HEIGHT)-1:0]   y,
    output logic [calc_width(IMG_WIDTH)-1:0]    win_x,
    output logic [calc_width(IMG_HEIGHT)-1:0]   win_y,
    output logic                                win_last,
    input  logic                                win_done,
`ifdef SCAN_SKIP_EN
    input  logic                                win_skip,
`endif
    output logic                                busy,
    output logic                                scan_done
);

    localparam int c_w_x = calc_width(IMG_WIDTH);
    localparam int c_w_y = calc_width(IMG_HEIGHT);
    localparam logic [c_w_x-1:0] c_i_last = c_w_x'(WIN_WIDTH - 1);
    localparam logic [c_w_y-1:0] c_j_last = c_w_y'(WIN_HEIGHT - 1);

    if (WIN_WIDTH > IMG_WIDTH || WIN_HEIGHT > IMG_HEIGHT || STEP < 1) begin : g_param_check
        $error("window_scan_ctrl: window must fit in image and STEP must be >= 1");
    end

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic             r_coord_valid;
    logic [c_w_x-1:0] r_x;
    logic [c_w_y-1:0] r_y;
    logic             r_win_last;
    logic             r_busy;
    logic             r_scan_done;

    logic             w_start_ok;
    logic             w_skip;
    logic             w_xfer;
    logic             w_last_px;
    logic             w_adv;
    logic             w_clr_px;
    logic [c_w_x-1:0] w_i, w_i_nxt, w_wx_nxt;
    logic [c_w_y-1:0] w_j, w_j_nxt, w_wy_nxt;
    logic             w_i_wrap, w_j_wrap, w_wx_wrap, w_wy_wrap;

    assign w_start_ok = start && (r_state == IDLE);
    assign w_xfer     = r_coord_valid && coord_ready;
    assign w_last_px  = w_i_wrap && w_j_wrap;
    assign w_adv      = (r_state == WAIT_RES) && win_done;

`ifdef SCAN_SKIP_EN
    assign w_skip = win_skip && (r_state == STREAM);
`else
    assign w_skip = 1'b0;
`endif

    // Pixel counters restart on a skip even if a transfer coincides with it
    assign w_clr_px = w_skip || w_start_ok;

    wrap_cnt #(.WIDTH(c_w_x), .MAX(WIN_WIDTH - 1), .INC(1)) u_i_cnt (
        .clk(clk), .rst(rst), .clr(w_clr_px), .en(w_xfer),
        .cnt(w_i), .wrap(w_i_wrap), .nxt(w_i_nxt)
    );

    wrap_cnt #(.WIDTH(c_w_y), .MAX(WIN_HEIGHT - 1), .INC(1)) u_j_cnt (
        .clk(clk), .rst(rst), .clr(w_clr_px), .en(w_xfer && w_i_wrap),
        .cnt(w_j), .wrap(w_j_wrap), .nxt(w_j_nxt)
    );

    wrap_cnt #(.WIDTH(c_w_x), .MAX(IMG_WIDTH - WIN_WIDTH), .INC(STEP)) u_wx_cnt (
        .clk(clk), .rst(rst), .clr(w_start_ok), .en(w_adv),
        .cnt(win_x), .wrap(w_wx_wrap), .nxt(w_wx_nxt)
    );

    wrap_cnt #(.WIDTH(c_w_y), .MAX(IMG_HEIGHT - WIN_HEIGHT), .INC(STEP)) u_wy_cnt (
        .clk(clk), .rst(rst), .clr(w_start_ok), .en(w_adv && w_wx_wrap),
        .cnt(win_y), .wrap(w_wy_wrap), .nxt(w_wy_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = STREAM;
            end
            STREAM: begin
                if (w_skip || (w_xfer && w_last_px)) w_state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (win_done) w_state_nxt = (w_wx_wrap && w_wy_wrap) ? DONE : STREAM;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they align with the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_coord_valid <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_win_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_scan_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_coord_valid <= (w_state_nxt == STREAM);
            r_x           <= w_wx_nxt + w_i_nxt;
            r_y           <= w_wy_nxt + w_j_nxt;
            r_win_last    <= (w_state_nxt == STREAM) && (w_i_nxt == c_i_last) && (w_j_nxt == c_j_last);
            r_busy        <= (w_state_nxt != IDLE);
            r_scan_done   <= (w_state_nxt == DONE);
        end
    end

    assign coord_valid = r_coord_valid;
    assign x           = r_x;
    assign y           = r_y;
    assign win_last    = r_win_last;
    assign busy        = r_busy;
    assign scan_done   = r_scan_done;

endmodule

`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
// ============================================================================
// Module      : tb_window_scan_ctrl
// Description : Self-checking bench for window_scan_ctrl on a 6x5 image with
//               a 3x2 window; SCAN_SKIP_EN enables the skip scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_scan_ctrl;

    localparam int IW = 6;
    localparam int IH = 5;
    localparam int WW = 3;
    localparam int WH = 2;
    localparam int ST = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       coord_ready;
    logic       win_done;
`ifdef SCAN_SKIP_EN
    logic       win_skip;
`endif
    logic       coord_valid;
    logic [2:0] x, y, win_x, win_y;
    logic       win_last;
    logic       busy;
    logic       scan_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int x;
        int y;
        int wx;
        int wy;
        int last;
    } px_t;

    always #5 clk = ~clk;

    window_scan_ctrl #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_WIDTH(WW), .WIN_HEIGHT(WH), .STEP(ST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .coord_valid(coord_valid),
        .coord_ready(coord_ready),
        .x(x),
        .y(y),
        .win_x(win_x),
        .win_y(win_y),
        .win_last(win_last),
        .win_done(win_done),
`ifdef SCAN_SKIP_EN
        .win_skip(win_skip),
`endif
        .busy(busy),
        .scan_done(scan_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full scan against a queue of every expected coordinate, built from nested loops
    task automatic run_scan(input int ready_pct);
        px_t q[$];
        px_t e;
        int  n_windows = 0;
        int  wins_done = 0;
        int  wait_cnt = -1;
        int  cycles = 0;
        int  scan_pulses = 0;
        bit  finished = 0;
        bit  stalled = 0;
        int  sx = 0, sy = 0, sl = 0;

        for (int wy = 0; wy + WH <= IH; wy += ST) begin
            for (int wx = 0; wx + WW <= IW; wx += ST) begin
                n_windows++;
                for (int j = 0; j < WH; j++) begin
                    for (int i = 0; i < WW; i++) begin
                        e.x = wx + i; e.y = wy + j; e.wx = wx; e.wy = wy;
                        e.last = (i == WW - 1 && j == WH - 1) ? 1 : 0;
                        q.push_back(e);
                    end
                end
            end
        end

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_valid", 32'(coord_valid), 1);

        while (!finished && cycles < 20000) begin
            win_done = 1'b0;
            if (scan_done) scan_pulses++;
            if (coord_valid) begin
                if (wait_cnt >= 0) check("valid_while_waiting", 1, 0);
                if (stalled) begin
                    check("stall_x", 32'(x), sx);
                    check("stall_y", 32'(y), sy);
                    check("stall_last", 32'(win_last), sl);
                end
                coord_ready = ($urandom_range(99) < ready_pct);
                if (coord_ready) begin
                    stalled = 0;
                    if (q.size() == 0) begin
                        check("extra_coord", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("x", 32'(x), e.x);
                        check("y", 32'(y), e.y);
                        check("win_x", 32'(win_x), e.wx);
                        check("win_y", 32'(win_y), e.wy);
                        check("win_last", 32'(win_last), e.last);
                        if (e.last != 0) wait_cnt = 3;
                    end
                end else begin
                    stalled = 1; sx = int'(x); sy = int'(y); sl = int'(win_last);
                end
            end else begin
                coord_ready = ($urandom_range(99) < ready_pct);
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        win_done = 1'b1;
                        wait_cnt = -1;
                        wins_done++;
                        if (wins_done == n_windows) finished = 1;
                    end
                end
            end
            @(negedge clk);
            cycles++;
        end
        win_done = 1'b0;
        coord_ready = 1'b0;
        if (!finished) check("scan_timeout", 0, 1);
        if (scan_done) scan_pulses++;
        check("done_busy", 32'(busy), 1);
        repeat (4) begin
            @(negedge clk);
            if (scan_done) scan_pulses++;
        end
        check("scan_done_pulses", scan_pulses, 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(coord_valid), 0);
        check("coords_left", q.size(), 0);
        check("windows", wins_done, 16);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; coord_ready = 1'b0; win_done = 1'b0;
`ifdef SCAN_SKIP_EN
        win_skip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(coord_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_scan_done", 32'(scan_done), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_win_x", 32'(win_x), 0);
        check("rst_win_y", 32'(win_y), 0);
        check("rst_win_last", 32'(win_last), 0);
        rst = 1'b0;

        run_scan(100);

        // Ignored start / win_done while streaming, then reset mid-stream
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; coord_ready = 1'b1;
        @(negedge clk);
        check("stream_x1", 32'(x), 1);
        coord_ready = 1'b0; start = 1'b1; win_done = 1'b1;
        @(negedge clk);
        start = 1'b0; win_done = 1'b0;
        check("ign_x", 32'(x), 1);
        check("ign_y", 32'(y), 0);
        check("ign_win_x", 32'(win_x), 0);
        check("ign_valid", 32'(coord_valid), 1);
        check("ign_busy", 32'(busy), 1);
        coord_ready = 1'b1;
        @(negedge clk);
        check("resume_x", 32'(x), 2);
        rst = 1'b1; coord_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(coord_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_win_x", 32'(win_x), 0);
        check("mid_rst_win_y", 32'(win_y), 0);
        check("mid_rst_x", 32'(x), 0);
        @(negedge clk);
        rst = 1'b0;

        run_scan(50);

`ifdef SCAN_SKIP_EN
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; coord_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("skip_pre_x", 32'(x), 2);
        coord_ready = 1'b0; win_skip = 1'b1;
        @(negedge clk);
        win_skip = 1'b0;
        check("skip_valid", 32'(coord_valid), 0);
        check("skip_busy", 32'(busy), 1);
        win_done = 1'b1;
        @(negedge clk);
        win_done = 1'b0;
        check("skip_next_valid", 32'(coord_valid), 1);
        check("skip_next_win_x", 32'(win_x), 1);
        check("skip_next_x", 32'(x), 1);
        check("skip_next_y", 32'(y), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
